// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: FSM state encoding,
// default hazard-controller parameters and the hard-wired zero register index.
package mips_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W       = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use interlock,
// data-memory wait with timeout, WB-resolved redirects, and stall/redirect counters.
module pipeline_hazard_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             redirect,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_abort,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count,
  output logic             state
);

  localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  state_e          st, st_nx;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nx;
  logic            load_use;
  logic            timeout;
  logic            stall_inc;

  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      st       <= st_nx;
      wait_cnt <= wait_cnt_nx;
      if (timeout) mem_error <= 1'b1;
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    mem_abort    = 1'b0;
    timeout      = 1'b0;
    st_nx        = st;
    wait_cnt_nx  = wait_cnt;

    if (redirect) begin
      // Redirect overrides everything: squash younger stages, cancel any access.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_abort    = mem_req;
      st_nx        = RUN;
      wait_cnt_nx  = '0;
    end else begin
      unique case (st)
        RUN: begin
          if (mem_req && !mem_ready) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            st_nx        = MEM_WAIT;
            wait_cnt_nx  = WC_ONE;
          end else if (load_use) begin
            // id_ex_en stays high so the bubble is captured behind the load.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            st_nx       = RUN;
            wait_cnt_nx = '0;
          end else if (wait_cnt == WC_LAST) begin
            mem_abort    = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            timeout      = 1'b1;
            st_nx        = RUN;
            wait_cnt_nx  = '0;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            wait_cnt_nx  = wait_cnt + WC_ONE;
          end
        end
        default: begin
          st_nx       = RUN;
          wait_cnt_nx = '0;
        end
      endcase
    end

    // Outputs are forced low for as long as reset is held, independent of the clock.
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      mem_abort    = 1'b0;
      timeout      = 1'b0;
    end
  end

  // The timeout cycle releases the pipeline yet is still accounted as lost time.
  assign stall_inc = !pc_en || timeout;
  assign state     = st;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a default instance and a small one (timeout 4, 2-bit counters).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0, redirect = 1'b0;

  logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en;
  logic        a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_mem_wb_flush;
  logic        a_mem_abort, a_mem_error, a_state;
  logic [31:0] a_stall_cycles, a_redirect_count;

  logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en;
  logic        b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_mem_wb_flush;
  logic        b_mem_abort, b_mem_error, b_state;
  logic [1:0]  b_stall_cycles, b_redirect_count;

  int checks = 0;
  int failures = 0;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, mem_abort}
  localparam logic [8:0] O_DEF  = 9'b1111_0000_0;
  localparam logic [8:0] O_LU   = 9'b0011_0100_0;
  localparam logic [8:0] O_MW   = 9'b0000_0001_0;
  localparam logic [8:0] O_TO   = 9'b1111_0011_1;
  localparam logic [8:0] O_RDA  = 9'b1111_1110_1;
  localparam logic [8:0] O_RDN  = 9'b1111_1110_0;
  localparam logic [8:0] O_ZERO = 9'b0000_0000_0;

  typedef struct {
    bit         dut_b;
    logic [8:0] exp;
    logic       exp_st;
    string      name;
  } exp_t;

  exp_t sb[$];

  wire [8:0] a_vec = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_if_id_flush,
                      a_id_ex_flush, a_ex_mem_flush, a_mem_wb_flush, a_mem_abort};
  wire [8:0] b_vec = {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_if_id_flush,
                      b_id_ex_flush, b_ex_mem_flush, b_mem_wb_flush, b_mem_abort};

  pipeline_hazard_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_req(mem_req), .mem_ready(mem_ready),
    .redirect(redirect), .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en),
    .ex_mem_en(a_ex_mem_en), .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .ex_mem_flush(a_ex_mem_flush), .mem_wb_flush(a_mem_wb_flush), .mem_abort(a_mem_abort),
    .mem_error(a_mem_error), .stall_cycles(a_stall_cycles),
    .redirect_count(a_redirect_count), .state(a_state)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_req(mem_req), .mem_ready(mem_ready),
    .redirect(redirect), .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en),
    .ex_mem_en(b_ex_mem_en), .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .ex_mem_flush(b_ex_mem_flush), .mem_wb_flush(b_mem_wb_flush), .mem_abort(b_mem_abort),
    .mem_error(b_mem_error), .stall_cycles(b_stall_cycles),
    .redirect_count(b_redirect_count), .state(b_state)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: combinational outputs are sampled mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [8:0] act;
      logic       act_st;
      e      = sb.pop_front();
      act    = e.dut_b ? b_vec : a_vec;
      act_st = e.dut_b ? b_state : a_state;
      checks++;
      if ({act, act_st} !== {e.exp, e.exp_st}) begin
        failures++;
        $display("FAIL %s: got out=%b state=%b, expected out=%b state=%b",
                 e.name, act, act_st, e.exp, e.exp_st);
      end
    end
  end

  task automatic push(input bit dut_b, input logic [8:0] exp, input logic st, input string name);
    exp_t e;
    e.dut_b  = dut_b;
    e.exp    = exp;
    e.exp_st = st;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mrd, input logic [4:0] rd,
                       input logic req, input logic rdy, input logic redir);
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd; ex_rd = rd;
    mem_req = req; mem_ready = rdy; redirect = redir;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
    mem_req = 1'b0; mem_ready = 1'b0; redirect = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    push(1'b0, O_ZERO, 1'b0, "reset_out_a");
    push(1'b1, O_ZERO, 1'b0, "reset_out_b");
    settle();
    checks++;
    if ({a_stall_cycles, a_redirect_count, a_mem_error} !== 65'd0) begin
      failures++;
      $display("FAIL reset_regs_a: got %0d/%0d/%b, expected 0/0/0",
               a_stall_cycles, a_redirect_count, a_mem_error);
    end
    checks++;
    if ({b_stall_cycles, b_redirect_count, b_mem_error} !== 5'd0) begin
      failures++;
      $display("FAIL reset_regs_b: got %0d/%0d/%b, expected 0/0/0",
               b_stall_cycles, b_redirect_count, b_mem_error);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    push(1'b0, O_DEF, 1'b0, "post_reset_idle");
    settle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    push(1'b0, O_LU, 1'b0, "lu_rs");
    idle();
    push(1'b0, O_DEF, 1'b0, "lu_release");
    settle();
    checks++;
    if (a_stall_cycles !== 32'd1) begin
      failures++;
      $display("FAIL lu_stall_count: got %0d, expected 1", a_stall_cycles);
    end
    drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    push(1'b0, O_DEF, 1'b0, "lu_reg0");
    drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    push(1'b0, O_LU, 1'b0, "lu_rt");
    drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    push(1'b0, O_DEF, 1'b0, "lu_rt_unused");
    drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    push(1'b0, O_DEF, 1'b0, "lu_not_load");
    idle();
    settle();
    checks++;
    if (a_stall_cycles !== 32'd2) begin
      failures++;
      $display("FAIL lu_stall_count2: got %0d, expected 2", a_stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b0, "mw_c0");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b1, "mw_c1");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b1, "mw_c2");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    push(1'b0, O_DEF, 1'b1, "mw_release");
    idle();
    push(1'b0, O_DEF, 1'b0, "mw_back_run");
    settle();
    checks++;
    if ({a_stall_cycles, a_mem_error} !== {32'd3, 1'b0}) begin
      failures++;
      $display("FAIL mw_stall_count: got %0d err=%b, expected 3 err=0",
               a_stall_cycles, a_mem_error);
    end
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    push(1'b0, O_LU, 1'b0, "zero_wait_with_lu");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    push(1'b0, O_DEF, 1'b0, "zero_wait");
    idle();
    settle();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      push(1'b1, O_MW, (i != 0), "to_wait");
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b1, O_TO, 1'b1, "to_abort");
    idle();
    push(1'b1, O_DEF, 1'b0, "to_back_run");
    settle();
    checks++;
    if (b_mem_error !== 1'b1) begin
      failures++;
      $display("FAIL to_error_set: got %b, expected 1", b_mem_error);
    end
    idle();
    settle();
    checks++;
    if (b_mem_error !== 1'b1) begin
      failures++;
      $display("FAIL to_error_sticky: got %b, expected 1", b_mem_error);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      push(1'b1, O_MW, (i != 0), "to_rdy_wait");
    end
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    push(1'b1, O_DEF, 1'b1, "to_rdy_wins");
    idle();
    push(1'b1, O_DEF, 1'b0, "to_rdy_run");
    settle();
    checks++;
    if (b_mem_error !== 1'b0) begin
      failures++;
      $display("FAIL to_rdy_no_error: got %b, expected 0", b_mem_error);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b0, "rw_c0");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b1, "rw_c1");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    push(1'b0, O_RDA, 1'b1, "rw_redirect");
    idle();
    push(1'b0, O_DEF, 1'b0, "rw_run");
    settle();
    checks++;
    if ({a_redirect_count, a_stall_cycles} !== {32'd1, 32'd2}) begin
      failures++;
      $display("FAIL rw_counts: got redir=%0d stall=%0d, expected 1 and 2",
               a_redirect_count, a_stall_cycles);
    end
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    push(1'b0, O_RDN, 1'b0, "rlu_redirect");
    idle();
    push(1'b0, O_DEF, 1'b0, "rlu_idle");
    settle();
    checks++;
    if ({a_redirect_count, a_stall_cycles} !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL rlu_counts: got redir=%0d stall=%0d, expected 1 and 0",
               a_redirect_count, a_stall_cycles);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    push(1'b0, O_LU, 1'b0, "b2b_lu");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b0, "b2b_mw");
    drive(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b1, "b2b_lu_ignored_in_wait");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    push(1'b0, O_DEF, 1'b1, "b2b_release");
    idle();
    settle();
    checks++;
    if (a_stall_cycles !== 32'd3) begin
      failures++;
      $display("FAIL b2b_stall_count: got %0d, expected 3", a_stall_cycles);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
      push(1'b1, O_LU, 1'b0, "sat_lu");
    end
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      push(1'b1, O_RDN, 1'b0, "sat_redir");
    end
    idle();
    settle();
    checks++;
    if ({b_stall_cycles, b_redirect_count} !== 4'b11_11) begin
      failures++;
      $display("FAIL sat_counts: got stall=%0d redir=%0d, expected 3 and 3",
               b_stall_cycles, b_redirect_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b0, "rmw_c0");
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push(1'b0, O_MW, 1'b1, "rmw_c1");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(1'b0, O_ZERO, 1'b0, "rmw_reset_out");
    settle();
    checks++;
    if (a_stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL rmw_counter_clear: got %0d, expected 0", a_stall_cycles);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_req = 1'b0;
    idle();
    push(1'b0, O_DEF, 1'b0, "rmw_after");
    settle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_redirect_wait();
    test_redirect_load_use();
    test_back_to_back();
    test_saturation();
    test_reset_mid_wait();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
